// File: rtl/frv_lsu_rsp_queue_pkg.sv
// Shared definitions for the LSU response queue: size encodings, trap causes
// and the bit layout of a queue entry's metadata word.
package frv_lsu_rsp_queue_pkg;

  typedef enum logic [1:0] {
    LSU_BYTE   = 2'd0,
    LSU_HALF   = 2'd1,
    LSU_WORD   = 2'd2,
    LSU_DOUBLE = 2'd3
  } lsu_size_e;

  localparam logic [5:0] TRAP_LDACCESS = 6'd5;
  localparam logic [5:0] TRAP_STACCESS = 6'd7;

  // Metadata word layout: {rd, size[1:0], signed, load}; address is stored apart.
  localparam int unsigned ENT_LOAD   = 0;
  localparam int unsigned ENT_SIGNED = 1;
  localparam int unsigned ENT_SIZE   = 2;
  localparam int unsigned ENT_RD     = 4;

endpackage

// File: rtl/frv_lsu_rsp_queue_if.sv
// Descriptor-enqueue, flush and data-memory response signals of the LSU
// response queue; master is the pipeline/bus side, slave is the queue.
interface frv_lsu_rsp_queue_if #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
);
  logic            enq_valid;
  logic            enq_ready;
  logic            enq_load;
  logic [1:0]      enq_size;
  logic            enq_signed;
  logic [RD_W-1:0] enq_rd;
  logic [XLEN-1:0] enq_addr;
  logic            flush;
  logic            dmem_recv;
  logic            dmem_ack;
  logic            dmem_error;
  logic [XLEN-1:0] dmem_rdata;

  modport master (
    output enq_valid, enq_load, enq_size, enq_signed, enq_rd, enq_addr,
    output flush, dmem_recv, dmem_error, dmem_rdata,
    input  enq_ready, dmem_ack
  );

  modport slave (
    input  enq_valid, enq_load, enq_size, enq_signed, enq_rd, enq_addr,
    input  flush, dmem_recv, dmem_error, dmem_rdata,
    output enq_ready, dmem_ack
  );
endinterface

// File: rtl/frv_lsu_rsp_queue_lane_extract.sv
// Combinational byte-lane extraction: shift the aligned response word down
// by the address offset, truncate to the access size and sign/zero extend.
module frv_lsu_lane_extract
  import frv_lsu_rsp_queue_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]            rdata,
  input  logic [$clog2(XLEN/8)-1:0]  addr_lo,
  input  logic [1:0]                 size,
  input  logic                       sgn,
  output logic [XLEN-1:0]            result
);
  localparam int IDX_W = $clog2(XLEN);
  localparam logic [IDX_W-1:0] TOP = IDX_W'(XLEN - 1);

  logic [XLEN-1:0]  shifted;
  logic [XLEN-1:0]  keep;
  logic [IDX_W-1:0] msb;
  logic             sbit;

  always_comb begin
    shifted = rdata >> {addr_lo, 3'b000};
    case (size)
      LSU_BYTE: msb = IDX_W'(7);
      LSU_HALF: msb = IDX_W'(15);
      // Double on a 32-bit datapath degrades to a word access.
      default:  msb = (size == LSU_DOUBLE && XLEN == 64) ? TOP : IDX_W'(31);
    endcase
    keep   = '1;
    keep   = keep >> (TOP - msb);
    sbit   = sgn & shifted[msb];
    result = (shifted & keep) | ({XLEN{sbit}} & ~keep);
  end
endmodule

// File: rtl/frv_lsu_rsp_queue.sv
// In-order queue of outstanding data-memory transactions feeding GPR writeback
// and bus-error traps. Optional FRV_LSU_RSP_SCOREBOARD_EN adds hazard_mask.
module frv_lsu_rsp_queue
  import frv_lsu_rsp_queue_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int RD_W  = 5
) (
  input  logic                 g_clk,
  input  logic                 g_reset,
  frv_lsu_rsp_queue_if.slave   lsu,
  output logic                 gpr_wen,
  output logic [RD_W-1:0]      gpr_rd,
  output logic [XLEN-1:0]      gpr_wdata,
  output logic                 trap_valid,
  output logic [5:0]           trap_cause,
  output logic [XLEN-1:0]      trap_mtval,
  output logic                 busy
`ifdef FRV_LSU_RSP_SCOREBOARD_EN
  ,
  output logic [2**RD_W-1:0]   hazard_mask
`endif
);
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int META_W = ENT_RD + RD_W;
  localparam int OFF_W  = $clog2(XLEN / 8);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [META_W-1:0] ent_meta [DEPTH];
  logic [XLEN-1:0]   ent_addr [DEPTH];
  logic [DEPTH-1:0]  ent_sq;
  logic [DEPTH-1:0]  ent_vld;
  logic [PTR_W-1:0]  head, tail;
  logic [CNT_W-1:0]  count;

  logic              enq_fire, deq_fire, head_sq;
  logic [META_W-1:0] head_meta;
  logic [XLEN-1:0]   head_addr;
  logic [RD_W-1:0]   head_rd;
  logic [XLEN-1:0]   ext_data;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign lsu.enq_ready = (count < FULL);
  assign lsu.dmem_ack  = (count != '0);
  assign busy          = (count != '0);

  assign enq_fire  = lsu.enq_valid && (count < FULL);
  assign deq_fire  = lsu.dmem_recv && (count != '0);
  assign head_meta = ent_meta[head];
  assign head_addr = ent_addr[head];
  assign head_rd   = head_meta[ENT_RD +: RD_W];
  // A flush in the consuming cycle squashes the head being retired.
  assign head_sq   = ent_sq[head] | lsu.flush;

  frv_lsu_lane_extract #(.XLEN(XLEN)) u_extract (
    .rdata   (lsu.dmem_rdata),
    .addr_lo (head_addr[OFF_W-1:0]),
    .size    (head_meta[ENT_SIZE +: 2]),
    .sgn     (head_meta[ENT_SIGNED]),
    .result  (ext_data)
  );

  always_ff @(posedge g_clk) begin
    if (enq_fire) begin
      ent_meta[tail] <= {lsu.enq_rd, lsu.enq_size, lsu.enq_signed, lsu.enq_load};
      ent_addr[tail] <= lsu.enq_addr;
    end
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      ent_sq     <= '0;
      ent_vld    <= '0;
      gpr_wen    <= 1'b0;
      gpr_rd     <= '0;
      gpr_wdata  <= '0;
      trap_valid <= 1'b0;
      trap_cause <= '0;
      trap_mtval <= '0;
    end else begin
      gpr_wen    <= 1'b0;
      trap_valid <= 1'b0;
      if (lsu.flush) ent_sq <= ent_sq | ent_vld;
      if (deq_fire) begin
        head          <= ptr_inc(head);
        ent_vld[head] <= 1'b0;
        if (!head_sq) begin
          if (lsu.dmem_error) begin
            trap_valid <= 1'b1;
            trap_cause <= head_meta[ENT_LOAD] ? TRAP_LDACCESS : TRAP_STACCESS;
            trap_mtval <= head_addr;
          end else if (head_meta[ENT_LOAD] && head_rd != '0) begin
            gpr_wen   <= 1'b1;
            gpr_rd    <= head_rd;
            gpr_wdata <= ext_data;
          end
        end
      end
      // Placed after the flush update so a same-cycle enqueue stays live.
      if (enq_fire) begin
        tail          <= ptr_inc(tail);
        ent_vld[tail] <= 1'b1;
        ent_sq[tail]  <= 1'b0;
      end
      case ({enq_fire, deq_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef FRV_LSU_RSP_SCOREBOARD_EN
  always_comb begin
    hazard_mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ent_vld[i] && !ent_sq[i] && ent_meta[i][ENT_LOAD])
        hazard_mask[ent_meta[i][ENT_RD +: RD_W]] = 1'b1;
    end
    if (gpr_wen) hazard_mask[gpr_rd] = 1'b1;
    hazard_mask[0] = 1'b0;
  end
`endif
endmodule

// File: tb/tb_frv_lsu_rsp_queue.sv
// Self-checking bench: 32-bit/DEPTH=4 instance checked every cycle against a
// queue-based model; 64-bit/DEPTH=2 instance checks wide lane extraction.
`timescale 1ns/1ps
module tb_frv_lsu_rsp_queue;
  localparam int DEPTH_A = 4;

  logic g_clk = 1'b0;
  logic g_reset;
  always #5 g_clk = ~g_clk;

  frv_lsu_rsp_queue_if #(.XLEN(32), .RD_W(5)) bus_a ();
  frv_lsu_rsp_queue_if #(.XLEN(64), .RD_W(5)) bus_b ();

  logic        a_wen, a_trap, a_busy;
  logic [4:0]  a_rd;
  logic [31:0] a_wdata, a_mtval;
  logic [5:0]  a_cause;
  logic        b_wen, b_trap, b_busy;
  logic [4:0]  b_rd;
  logic [63:0] b_wdata, b_mtval;
  logic [5:0]  b_cause;
`ifdef FRV_LSU_RSP_SCOREBOARD_EN
  logic [31:0] a_haz, b_haz;
`endif

  frv_lsu_rsp_queue #(.XLEN(32), .DEPTH(DEPTH_A), .RD_W(5)) dut_a (
    .g_clk(g_clk), .g_reset(g_reset), .lsu(bus_a),
    .gpr_wen(a_wen), .gpr_rd(a_rd), .gpr_wdata(a_wdata),
    .trap_valid(a_trap), .trap_cause(a_cause), .trap_mtval(a_mtval),
    .busy(a_busy)
`ifdef FRV_LSU_RSP_SCOREBOARD_EN
    , .hazard_mask(a_haz)
`endif
  );

  frv_lsu_rsp_queue #(.XLEN(64), .DEPTH(2), .RD_W(5)) dut_b (
    .g_clk(g_clk), .g_reset(g_reset), .lsu(bus_b),
    .gpr_wen(b_wen), .gpr_rd(b_rd), .gpr_wdata(b_wdata),
    .trap_valid(b_trap), .trap_cause(b_cause), .trap_mtval(b_mtval),
    .busy(b_busy)
`ifdef FRV_LSU_RSP_SCOREBOARD_EN
    , .hazard_mask(b_haz)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference extraction: arithmetic on a 64-bit value, independent of xlen.
  function automatic logic [63:0] m_extract(input int xlen, input logic [63:0] data,
                                             input logic [63:0] addr, input logic [1:0] size,
                                             input bit sgn);
    int          off;
    int          bits;
    logic [63:0] sh, mask, v;
    off  = int'(addr[2:0]) % (xlen / 8);
    sh   = data >> (off * 8);
    bits = (size == 2'd0) ? 8 : (size == 2'd1) ? 16 : (size == 2'd2 || xlen == 32) ? 32 : 64;
    if (bits == 64) return sh;
    mask = (64'd1 << bits) - 64'd1;
    v    = sh & mask;
    if (sgn && v[bits-1]) v = v | ~mask;
    if (xlen == 32) v = v & 64'hFFFF_FFFF;
    return v;
  endfunction

  typedef struct {
    bit          load;
    logic [1:0]  size;
    bit          sgn;
    logic [4:0]  rd;
    logic [31:0] addr;
    bit          sq;
  } desc_t;

  desc_t       mq[$];
  bit          m_wen, m_trap;
  logic [4:0]  m_rd;
  logic [31:0] m_wdata, m_mtval;
  logic [5:0]  m_cause;

  // Model of instance A, stepped on every clock edge from the inputs it sees.
  always @(posedge g_clk) begin : model
    desc_t h, n;
    bit    deq, enq, sq;
    if (g_reset) begin
      mq.delete();
      m_wen = 0; m_trap = 0; m_rd = '0; m_wdata = '0; m_cause = '0; m_mtval = '0;
    end else begin
      deq = bus_a.dmem_recv && mq.size() != 0;
      enq = bus_a.enq_valid && mq.size() < DEPTH_A;
      m_wen = 0;
      m_trap = 0;
      if (deq) begin
        h  = mq.pop_front();
        sq = h.sq || bus_a.flush;
        if (!sq && bus_a.dmem_error) begin
          m_trap = 1; m_cause = h.load ? 6'd5 : 6'd7; m_mtval = h.addr;
        end else if (!sq && h.load && h.rd != 0) begin
          m_wen = 1; m_rd = h.rd;
          m_wdata = 32'(m_extract(32, 64'(bus_a.dmem_rdata), 64'(h.addr), h.size, h.sgn));
        end
      end
      if (bus_a.flush) foreach (mq[i]) mq[i].sq = 1;
      if (enq) begin
        n.load = bus_a.enq_load; n.size = bus_a.enq_size; n.sgn = bus_a.enq_signed;
        n.rd = bus_a.enq_rd; n.addr = bus_a.enq_addr; n.sq = 0;
        mq.push_back(n);
      end
    end
  end

`ifdef FRV_LSU_RSP_SCOREBOARD_EN
  function automatic logic [31:0] m_hazard();
    logic [31:0] m = '0;
    foreach (mq[i]) if (mq[i].load && !mq[i].sq) m[mq[i].rd] = 1'b1;
    if (m_wen) m[m_rd] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction
`endif

  always @(negedge g_clk) begin
    if (chk_en) begin
      check("enq_ready", bus_a.enq_ready, mq.size() < DEPTH_A);
      check("dmem_ack", bus_a.dmem_ack, mq.size() != 0);
      check("busy", a_busy, mq.size() != 0);
      check("gpr_wen", a_wen, m_wen);
      if (m_wen) begin
        check("gpr_rd", a_rd, m_rd);
        check("gpr_wdata", a_wdata, m_wdata);
      end
      check("trap_valid", a_trap, m_trap);
      if (m_trap) begin
        check("trap_cause", a_cause, m_cause);
        check("trap_mtval", a_mtval, m_mtval);
      end
`ifdef FRV_LSU_RSP_SCOREBOARD_EN
      check("hazard_mask", a_haz, m_hazard());
`endif
    end
  end

  task automatic drive_a(input bit ev, input bit ld, input logic [1:0] sz, input bit sg,
                         input logic [4:0] rd, input logic [31:0] addr, input bit fl,
                         input bit rv, input bit er, input logic [31:0] data);
    bus_a.enq_valid = ev; bus_a.enq_load = ld; bus_a.enq_size = sz; bus_a.enq_signed = sg;
    bus_a.enq_rd = rd; bus_a.enq_addr = addr; bus_a.flush = fl;
    bus_a.dmem_recv = rv; bus_a.dmem_error = er; bus_a.dmem_rdata = data;
    @(posedge g_clk);
    #1;
  endtask

  task automatic drive_b(input bit ev, input logic [1:0] sz, input bit sg, input logic [63:0] addr,
                         input bit rv, input logic [63:0] data);
    bus_b.enq_valid = ev; bus_b.enq_load = 1'b1; bus_b.enq_size = sz; bus_b.enq_signed = sg;
    bus_b.enq_rd = 5'd12; bus_b.enq_addr = addr; bus_b.flush = 1'b0;
    bus_b.dmem_recv = rv; bus_b.dmem_error = 1'b0; bus_b.dmem_rdata = data;
    @(posedge g_clk);
    #1;
  endtask

  initial begin
    logic [63:0] ra, rdat;
    logic [1:0]  rs;
    bit          rsg;
    g_reset = 1'b1;
    bus_a.enq_valid = 0; bus_a.enq_load = 0; bus_a.enq_size = '0; bus_a.enq_signed = 0;
    bus_a.enq_rd = '0; bus_a.enq_addr = '0; bus_a.flush = 0;
    bus_a.dmem_recv = 0; bus_a.dmem_error = 0; bus_a.dmem_rdata = '0;
    bus_b.enq_valid = 0; bus_b.enq_load = 0; bus_b.enq_size = '0; bus_b.enq_signed = 0;
    bus_b.enq_rd = '0; bus_b.enq_addr = '0; bus_b.flush = 0;
    bus_b.dmem_recv = 0; bus_b.dmem_error = 0; bus_b.dmem_rdata = '0;
    repeat (2) @(posedge g_clk);
    #1;
    chk_en = 1'b1;
    check("rst enq_ready", bus_a.enq_ready, 1);
    check("rst dmem_ack", bus_a.dmem_ack, 0);
    check("rst busy", a_busy, 0);
    check("rst gpr_wen", a_wen, 0);
    check("rst gpr_rd", a_rd, 0);
    check("rst gpr_wdata", a_wdata, 0);
    check("rst trap_valid", a_trap, 0);
    check("rst trap_cause", a_cause, 0);
    check("rst trap_mtval", a_mtval, 0);
    g_reset = 1'b0;

    // lbu rd=3 at 0x1001
    drive_a(1, 1, 2'd0, 0, 5'd3, 32'h1001, 0, 0, 0, '0);
    drive_a(0, 0, 2'd0, 0, 5'd0, '0, 0, 1, 0, 32'hAABBCCDD);
    check("lbu wen", a_wen, 1);
    check("lbu rd", a_rd, 3);
    check("lbu wdata", a_wdata, 32'h0000_00CC);

    // fill, then no full bypass
    for (int i = 0; i < 4; i++) drive_a(1, 1, 2'd2, 0, 5'(i + 1), 32'(32'h100 + i * 4), 0, 0, 0, '0);
    check("full enq_ready", bus_a.enq_ready, 0);
    drive_a(1, 1, 2'd2, 0, 5'd5, 32'h200, 0, 1, 0, 32'h1111_1111);
    check("nobypass enq_ready", bus_a.enq_ready, 1);
    check("nobypass rd", a_rd, 1);
    drive_a(1, 1, 2'd2, 0, 5'd5, 32'h200, 0, 0, 0, '0);
    check("fifth accepted", bus_a.enq_ready, 0);
    for (int i = 0; i < 4; i++) drive_a(0, 0, 2'd0, 0, 5'd0, '0, 0, 1, 0, 32'(32'h5000_0000 + i));
    check("drain rd", a_rd, 5);
    check("drain wdata", a_wdata, 32'h5000_0003);
    check("drain busy", a_busy, 0);

    // store bus error
    drive_a(1, 0, 2'd2, 0, 5'd4, 32'h2000, 0, 0, 0, '0);
    drive_a(0, 0, 2'd0, 0, 5'd0, '0, 0, 1, 1, '0);
    check("st trap", a_trap, 1);
    check("st cause", a_cause, 7);
    check("st mtval", a_mtval, 32'h2000);
    check("st wen", a_wen, 0);
    drive_a(0, 0, 2'd0, 0, 5'd0, '0, 0, 0, 0, '0);
    check("st trap 1cyc", a_trap, 0);

    // flush with a same-cycle enqueue
    drive_a(1, 1, 2'd2, 0, 5'd7, 32'h300, 0, 0, 0, '0);
    drive_a(1, 1, 2'd2, 0, 5'd8, 32'h304, 0, 0, 0, '0);
    drive_a(1, 1, 2'd2, 0, 5'd9, 32'h308, 1, 0, 0, '0);
    drive_a(0, 0, 2'd0, 0, 5'd0, '0, 0, 1, 0, 32'h1234_5678);
    check("sq1 wen", a_wen, 0);
    drive_a(0, 0, 2'd0, 0, 5'd0, '0, 0, 1, 1, 32'h1234_5678);
    check("sq2 trap", a_trap, 0);
    drive_a(0, 0, 2'd0, 0, 5'd0, '0, 0, 1, 0, 32'h1234_5678);
    check("post-flush wen", a_wen, 1);
    check("post-flush rd", a_rd, 9);
    check("post-flush wdata", a_wdata, 32'h1234_5678);

    // flush in the cycle the head is consumed
    drive_a(1, 1, 2'd2, 0, 5'd6, 32'h400, 0, 0, 0, '0);
    drive_a(0, 0, 2'd0, 0, 5'd0, '0, 1, 1, 0, 32'hDEAD);
    check("flush-head wen", a_wen, 0);

    // response on an empty queue, then load to x0
    check("empty ack", bus_a.dmem_ack, 0);
    drive_a(0, 0, 2'd0, 0, 5'd0, '0, 0, 1, 1, 32'hFFFF_FFFF);
    check("empty trap", a_trap, 0);
    check("empty busy", a_busy, 0);
    drive_a(1, 1, 2'd2, 0, 5'd0, 32'h500, 0, 0, 0, '0);
    drive_a(0, 0, 2'd0, 0, 5'd0, '0, 0, 1, 0, 32'h55);
    check("x0 wen", a_wen, 0);

    // reset with entries held
    for (int i = 0; i < 3; i++) drive_a(1, 1, 2'd2, 0, 5'd10, 32'h600, 0, 0, 0, '0);
    check("pre-rst busy", a_busy, 1);
    g_reset = 1'b1;
    drive_a(0, 0, 2'd0, 0, 5'd0, '0, 0, 0, 0, '0);
    g_reset = 1'b0;
    check("post-rst busy", a_busy, 0);
    check("post-rst enq_ready", bus_a.enq_ready, 1);
    drive_a(0, 0, 2'd0, 0, 5'd0, '0, 0, 1, 0, 32'h77);
    check("post-rst wen", a_wen, 0);

    // randomized traffic, checked by the per-cycle compare process
    for (int i = 0; i < 3000; i++) begin
      g_reset = ($urandom_range(0, 299) == 0);
      drive_a($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
              $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom,
              $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0,
              $urandom_range(0, 7) == 0, $urandom);
    end
    g_reset = 1'b0;
    drive_a(0, 0, 2'd0, 0, 5'd0, '0, 0, 0, 0, '0);

    // 64-bit instance: signed half at offset 6
    drive_b(1, 2'd1, 1, 64'h1006, 0, '0);
    drive_b(0, 2'd0, 0, '0, 1, 64'h8123_0000_0000_0000);
    check("x64 lh wen", b_wen, 1);
    check("x64 lh wdata", b_wdata, 64'hFFFF_FFFF_FFFF_8123);
    drive_b(1, 2'd2, 1, 64'h2004, 0, '0);
    drive_b(0, 2'd0, 0, '0, 1, 64'h8000_0000_0000_0000);
    check("x64 lw wdata", b_wdata, 64'hFFFF_FFFF_8000_0000);
    for (int i = 0; i < 100; i++) begin
      ra   = {$urandom, $urandom};
      rdat = {$urandom, $urandom};
      rs   = 2'($urandom_range(0, 3));
      rsg  = ($urandom_range(0, 1) == 1);
      drive_b(1, rs, rsg, ra, 0, '0);
      drive_b(0, 2'd0, 0, '0, 1, rdat);
      check("x64 rnd wen", b_wen, 1);
      check("x64 rnd wdata", b_wdata, m_extract(64, rdat, ra, rs, rsg));
    end
    check("x64 busy", b_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
